// File: rtl/i2cs_mailbox_fifo.sv
// ---------------------------------------------------------------------------
// i2cs_mailbox_fifo
// Byte mailbox on the register port of the I2C peripheral interface. The I2C
// master sees an 8-bit register map with an ID byte, two FIFOs and status:
//   RXF : I2C -> host. The I2C master pushes bytes; host logic drains them.
//   TXF : host -> I2C. Host logic fills it; the I2C master pops it by reading.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   i2c_reg_addr_i [7:0]          register address from the I2C interface
//   i2c_reg_wdata_i [7:0]         write data, qualified by i2c_reg_wrenable_i
//   i2c_reg_wrenable_i            one-cycle write strobe
//   i2c_reg_rddata_o [7:0]        combinational read data for i2c_reg_addr_i
//   i2c_reg_rd_byte_complete_i    pulse: the byte at i2c_reg_addr_i was sent
//   rx_data_o/rx_valid_o/rx_ready_i   RXF head stream to the host
//   tx_data_i/tx_valid_i/tx_ready_o   host stream into TXF
//   irq_o                         RXF not empty, or a sticky error is set
//
// Map: 0x00 ID, 0x10 RXF push (WO), 0x11 TXF pop (RO), 0x12 STATUS,
//      0x13 RXF count, 0x14 TXF count, 0x15 CTRL (WO, self-clearing).
// ---------------------------------------------------------------------------
module i2cs_mailbox_fifo #(
   parameter int unsigned DEPTH      = 8,
   parameter logic [7:0]  ID_VALUE   = 8'h5A,
   parameter logic [7:0]  EMPTY_BYTE = 8'hFF
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [7:0] i2c_reg_addr_i,
   input  logic [7:0] i2c_reg_wdata_i,
   input  logic       i2c_reg_wrenable_i,
   output logic [7:0] i2c_reg_rddata_o,
   input  logic       i2c_reg_rd_byte_complete_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic       irq_o
);

   localparam int unsigned   AW       = $clog2(DEPTH);
   localparam int unsigned   CW       = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   localparam logic [7:0] A_ID     = 8'h00;
   localparam logic [7:0] A_RXPUSH = 8'h10;
   localparam logic [7:0] A_TXPOP  = 8'h11;
   localparam logic [7:0] A_STATUS = 8'h12;
   localparam logic [7:0] A_RXCNT  = 8'h13;
   localparam logic [7:0] A_TXCNT  = 8'h14;
   localparam logic [7:0] A_CTRL   = 8'h15;

   logic [7:0]    r_rx_mem [DEPTH];
   logic [AW-1:0] r_rx_wptr, r_rx_rptr;
   logic [CW-1:0] r_rx_cnt;
   logic [7:0]    r_tx_mem [DEPTH];
   logic [AW-1:0] r_tx_wptr, r_tx_rptr;
   logic [CW-1:0] r_tx_cnt;
   logic          r_ovf, r_unf;

   logic w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
   logic w_ctrl_wr, w_rx_flush, w_tx_flush;
   logic w_rx_push_req, w_rx_push, w_rx_pop;
   logic w_tx_pop_req, w_tx_pop, w_tx_push;
   logic w_ovf_set, w_unf_set;

   assign w_rx_full  = (r_rx_cnt == FULL_CNT);
   assign w_rx_empty = (r_rx_cnt == '0);
   assign w_tx_full  = (r_tx_cnt == FULL_CNT);
   assign w_tx_empty = (r_tx_cnt == '0);

   assign w_ctrl_wr  = i2c_reg_wrenable_i && (i2c_reg_addr_i == A_CTRL);
   assign w_rx_flush = w_ctrl_wr && i2c_reg_wdata_i[6];
   assign w_tx_flush = w_ctrl_wr && i2c_reg_wdata_i[7];

   // All decisions use pre-edge fullness: a full RXF drops the I2C byte even
   // when the host pops in the same cycle. A flush swallows concurrent traffic.
   assign w_rx_push_req = i2c_reg_wrenable_i && (i2c_reg_addr_i == A_RXPUSH);
   assign w_rx_push     = w_rx_push_req && !w_rx_full && !w_rx_flush;
   assign w_rx_pop      = !w_rx_empty && rx_ready_i && !w_rx_flush;
   assign w_ovf_set     = w_rx_push_req && w_rx_full && !w_rx_flush;

   assign w_tx_pop_req = i2c_reg_rd_byte_complete_i && (i2c_reg_addr_i == A_TXPOP);
   assign w_tx_pop     = w_tx_pop_req && !w_tx_empty && !w_tx_flush;
   assign w_tx_push    = tx_valid_i && !w_tx_full && !w_tx_flush;
   assign w_unf_set    = w_tx_pop_req && w_tx_empty && !w_tx_flush;

   // Storage is deliberately left out of reset; pointers alone define content.
   always_ff @(posedge clk_i) begin
      if (w_rx_push) r_rx_mem[r_rx_wptr] <= i2c_reg_wdata_i;
      if (w_tx_push) r_tx_mem[r_tx_wptr] <= tx_data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rx_wptr <= '0;
         r_rx_rptr <= '0;
         r_rx_cnt  <= '0;
      end else if (w_rx_flush) begin
         r_rx_wptr <= '0;
         r_rx_rptr <= '0;
         r_rx_cnt  <= '0;
      end else begin
         if (w_rx_push) r_rx_wptr <= r_rx_wptr + AW'(1);
         if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + AW'(1);
         if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + CW'(1);
         else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_tx_wptr <= '0;
         r_tx_rptr <= '0;
         r_tx_cnt  <= '0;
      end else if (w_tx_flush) begin
         r_tx_wptr <= '0;
         r_tx_rptr <= '0;
         r_tx_cnt  <= '0;
      end else begin
         if (w_tx_push) r_tx_wptr <= r_tx_wptr + AW'(1);
         if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + AW'(1);
         if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + CW'(1);
         else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - CW'(1);
      end
   end

   // Sticky flags: a set in the same cycle as a clear wins.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         if (w_ovf_set)                           r_ovf <= 1'b1;
         else if (w_ctrl_wr && i2c_reg_wdata_i[4]) r_ovf <= 1'b0;
         if (w_unf_set)                           r_unf <= 1'b1;
         else if (w_ctrl_wr && i2c_reg_wdata_i[5]) r_unf <= 1'b0;
      end
   end

   always_comb begin
      i2c_reg_rddata_o = 8'h00;
      case (i2c_reg_addr_i)
         A_ID:     i2c_reg_rddata_o = ID_VALUE;
         A_TXPOP:  i2c_reg_rddata_o = w_tx_empty ? EMPTY_BYTE : r_tx_mem[r_tx_rptr];
         A_STATUS: i2c_reg_rddata_o = {2'b00, r_unf, r_ovf,
                                       w_tx_empty, w_tx_full, w_rx_empty, w_rx_full};
         A_RXCNT:  i2c_reg_rddata_o = {{(8-CW){1'b0}}, r_rx_cnt};
         A_TXCNT:  i2c_reg_rddata_o = {{(8-CW){1'b0}}, r_tx_cnt};
         default:  i2c_reg_rddata_o = 8'h00;
      endcase
   end

   assign rx_data_o  = r_rx_mem[r_rx_rptr];
   assign rx_valid_o = !w_rx_empty;
   assign tx_ready_o = !w_tx_full;
   assign irq_o      = !w_rx_empty || r_ovf || r_unf;

endmodule
